// File: rtl/ddr3_avalon_bridge_if.sv
// Avalon-MM master bus bundle for the DDR3 SDRAM bridge.
// The master modport is the bridge side; the slave modport is the SDRAM side.
interface ddr3_avalon_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
);
    logic [ADDR_WIDTH-1:0]   avm_address;
    logic                    avm_read;
    logic                    avm_write;
    logic [DATA_WIDTH-1:0]   avm_writedata;
    logic [DATA_WIDTH/8-1:0] avm_byteenable;
    logic [DATA_WIDTH-1:0]   avm_readdata;
    logic                    avm_readdatavalid;
    logic                    avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        output avm_write,
        output avm_writedata,
        output avm_byteenable,
        input  avm_readdata,
        input  avm_readdatavalid,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        input  avm_write,
        input  avm_writedata,
        input  avm_byteenable,
        output avm_readdata,
        output avm_readdatavalid,
        output avm_waitrequest
    );
endinterface

// File: rtl/ddr3_avalon_bridge.sv
// Single-outstanding word request bridge from the image core to Avalon-MM SDRAM.
// Optional read watchdog and sticky error flag: define DDR3_BRIDGE_TIMEOUT_EN.
module ddr3_avalon_bridge #(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 128,
    parameter logic [31:0] BASE_ADDR      = 32'h2000_0000,
    parameter int          WORD_SHIFT     = 4,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           sdram_address,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] write_data_input,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  write_complete,
    output logic                  read_complete,
    output logic                  busy,
    output logic                  error,
    ddr3_avalon_bridge_if.master  avm
);

    localparam int BE_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        WR_REQ,
        RD_REQ,
        RD_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic                  wc_q, wc_d;
    logic                  rc_q, rc_d;
    logic                  pend_q, pend_d;
    logic [31:0]           pend_addr_q, pend_addr_d;

    function automatic logic [ADDR_WIDTH-1:0] map_addr(
        input logic [31:0] word
    );
        logic [ADDR_WIDTH-1:0] base;
        logic [ADDR_WIDTH-1:0] off;
        base = ADDR_WIDTH'(BASE_ADDR);
        off  = ADDR_WIDTH'(word) << WORD_SHIFT;
        return base + off;
    endfunction

`ifdef DDR3_BRIDGE_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;
    logic        err_q, err_d;
    logic        in_rd;
    assign in_rd = (state_q == RD_REQ) || (state_q == RD_WAIT);
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        wc_d        = 1'b0;
        rc_d        = 1'b0;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        case (state_q)
            IDLE: begin
                // A read queued behind a colliding write goes first.
                if (pend_q) begin
                    state_d = RD_REQ;
                    addr_d  = map_addr(pend_addr_q);
                    rd_d    = 1'b1;
                    pend_d  = 1'b0;
                end else if (wr_en) begin
                    state_d = WR_REQ;
                    addr_d  = map_addr(sdram_address);
                    wdata_d = write_data_input;
                    wr_d    = 1'b1;
                    if (rd_en) begin
                        pend_d      = 1'b1;
                        pend_addr_d = sdram_address;
                    end
                end else if (rd_en) begin
                    state_d = RD_REQ;
                    addr_d  = map_addr(sdram_address);
                    rd_d    = 1'b1;
                end
            end
            WR_REQ: begin
                if (!avm.avm_waitrequest) begin
                    wr_d    = 1'b0;
                    wc_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            RD_REQ: begin
                if (!avm.avm_waitrequest) begin
                    rd_d = 1'b0;
                    if (avm.avm_readdatavalid) begin
                        rdata_d = avm.avm_readdata;
                        rc_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (avm.avm_readdatavalid) begin
                    rdata_d = avm.avm_readdata;
                    rc_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef DDR3_BRIDGE_TIMEOUT_EN
        tmo_d = in_rd ? tmo_q + 16'd1 : 16'd0;
        err_d = err_q;
        // Real data arriving on the limit cycle wins over the watchdog.
        if (in_rd && !rc_d &&
            (tmo_q == 16'(TIMEOUT_CYCLES - 1))) begin
            state_d = IDLE;
            rd_d    = 1'b0;
            rdata_d = '0;
            rc_d    = 1'b1;
            err_d   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            wc_q        <= 1'b0;
            rc_q        <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            wc_q        <= wc_d;
            rc_q        <= rc_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

`ifdef DDR3_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    assign read_data          = rdata_q;
    assign write_complete     = wc_q;
    assign read_complete      = rc_q;
    assign busy               = (state_q != IDLE) || pend_q;
    assign avm.avm_address    = addr_q;
    assign avm.avm_read       = rd_q;
    assign avm.avm_write      = wr_q;
    assign avm.avm_writedata  = wdata_q;
    assign avm.avm_byteenable = (rd_q || wr_q) ? {BE_W{1'b1}} : '0;

endmodule

// File: tb/tb_ddr3_avalon_bridge.sv
// Randomized scenario bench for ddr3_avalon_bridge.
// Expected addresses, data and pulse timing come from a small transaction model.
module tb_ddr3_avalon_bridge;

    localparam int AW = 32;
    localparam int DW = 128;
`ifdef DDR3_BRIDGE_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   sdram_address;
    logic          rd_en;
    logic          wr_en;
    logic [DW-1:0] write_data_input;
    logic [DW-1:0] read_data;
    logic          write_complete;
    logic          read_complete;
    logic          busy;
    logic          error;

    ddr3_avalon_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) avm ();

    ddr3_avalon_bridge #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .BASE_ADDR(32'h2000_0000),
        .WORD_SHIFT(4),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sdram_address(sdram_address),
        .rd_en(rd_en),
        .wr_en(wr_en),
        .write_data_input(write_data_input),
        .read_data(read_data),
        .write_complete(write_complete),
        .read_complete(read_complete),
        .busy(busy),
        .error(error),
        .avm(avm)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] model_rdata;

    function automatic logic [31:0] exp_addr(input logic [31:0] w);
        return 32'h2000_0000 + w * 32'd16;
    endfunction

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b0; rd_en = 0; wr_en = 0;
        sdram_address = '0; write_data_input = '0;
        avm.avm_readdata = '0; avm.avm_readdatavalid = 0;
        avm.avm_waitrequest = 0;
        #12;
        n_cmp++;
        if ({read_data, write_complete, read_complete, busy, error} !== '0) begin
            n_err++;
            $display("FAIL reset_core: got rd=%h wc=%b rc=%b busy=%b err=%b want 0",
                     read_data, write_complete, read_complete, busy, error);
        end
        n_cmp++;
        if ({avm.avm_address, avm.avm_read, avm.avm_write,
             avm.avm_writedata, avm.avm_byteenable} !== '0) begin
            n_err++;
            $display("FAIL reset_avm: got addr=%h r=%b w=%b be=%h want 0",
                     avm.avm_address, avm.avm_read, avm.avm_write,
                     avm.avm_byteenable);
        end
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, avm.avm_read, avm.avm_write, write_complete} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_idle: got %b want 0000",
                     {busy, avm.avm_read, avm.avm_write, write_complete});
        end
        model_rdata = '0;
    endtask

    task automatic test_write(input logic [31:0] a, input logic [DW-1:0] d,
                              input int waits);
        logic [31:0] ea;
        ea = exp_addr(a);
        @(negedge clk);
        sdram_address = a; write_data_input = d; wr_en = 1;
        for (int n = 1; n <= waits + 1; n++) begin
            @(negedge clk);
            n_cmp++;
            if ({avm.avm_write, avm.avm_read, write_complete, busy} !== 4'b1001) begin
                n_err++;
                $display("FAIL wr_strobe beat%0d: got w,r,wc,busy=%b want 1001", n,
                         {avm.avm_write, avm.avm_read, write_complete, busy});
            end
            n_cmp++;
            if (avm.avm_address !== ea || avm.avm_writedata !== d ||
                avm.avm_byteenable !== 16'hFFFF) begin
                n_err++;
                $display("FAIL wr_bus beat%0d: got addr=%h data=%h be=%h want %h %h ffff",
                         n, avm.avm_address, avm.avm_writedata,
                         avm.avm_byteenable, ea, d);
            end
            avm.avm_waitrequest = (n <= waits);
            sdram_address = $urandom;
            write_data_input = rnd128();
        end
        @(negedge clk);
        n_cmp++;
        if ({write_complete, avm.avm_write, avm.avm_byteenable} !== {1'b1, 1'b0, 16'h0}) begin
            n_err++;
            $display("FAIL wr_complete: got wc=%b w=%b be=%h want 1 0 0000",
                     write_complete, avm.avm_write, avm.avm_byteenable);
        end
        wr_en = 0;
        @(negedge clk);
        n_cmp++;
        if ({write_complete, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL wr_after: got wc=%b busy=%b want 0 0", write_complete, busy);
        end
    endtask

    task automatic test_read(input logic [31:0] a, input logic [DW-1:0] d,
                             input int waits, input int lat);
        logic [31:0] ea;
        ea = exp_addr(a);
        @(negedge clk);
        sdram_address = a; rd_en = 1;
        for (int n = 1; n <= waits + 1; n++) begin
            @(negedge clk);
            n_cmp++;
            if ({avm.avm_read, avm.avm_write, read_complete, busy} !== 4'b1001 ||
                avm.avm_address !== ea || avm.avm_byteenable !== 16'hFFFF) begin
                n_err++;
                $display("FAIL rd_strobe beat%0d: got r,w,rc,busy=%b addr=%h be=%h want 1001 %h ffff",
                         n, {avm.avm_read, avm.avm_write, read_complete, busy},
                         avm.avm_address, avm.avm_byteenable, ea);
            end
            avm.avm_waitrequest = (n <= waits);
            sdram_address = $urandom;
            avm.avm_readdatavalid = (n == waits + 1) && (lat == 0);
            avm.avm_readdata = avm.avm_readdatavalid ? d : rnd128();
        end
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({avm.avm_read, read_complete, busy} !== 3'b001 ||
                read_data !== model_rdata) begin
                n_err++;
                $display("FAIL rd_wait k%0d: got r,rc,busy=%b data=%h want 001 %h",
                         k, {avm.avm_read, read_complete, busy}, read_data, model_rdata);
            end
            avm.avm_readdatavalid = (k == lat);
            avm.avm_readdata = (k == lat) ? d : rnd128();
        end
        @(negedge clk);
        avm.avm_readdatavalid = 0; avm.avm_readdata = rnd128();
        n_cmp++;
        if (read_complete !== 1'b1 || read_data !== d) begin
            n_err++;
            $display("FAIL rd_complete: got rc=%b data=%h want 1 %h",
                     read_complete, read_data, d);
        end
        rd_en = 0;
        model_rdata = d;
        @(negedge clk);
        n_cmp++;
        if ({read_complete, busy} !== 2'b00 || read_data !== model_rdata) begin
            n_err++;
            $display("FAIL rd_after: got rc=%b busy=%b data=%h want 0 0 %h",
                     read_complete, busy, read_data, model_rdata);
        end
    endtask

    task automatic test_collision(input logic [31:0] a, input logic [DW-1:0] d,
                                  input logic [DW-1:0] rd);
        logic [31:0] ea;
        int          wc_n;
        int          rc_n;
        ea = exp_addr(a);
        wc_n = 0; rc_n = 0;
        @(negedge clk);
        sdram_address = a; write_data_input = d;
        wr_en = 1; rd_en = 1; avm.avm_waitrequest = 0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            wc_n += int'(write_complete);
            rc_n += int'(read_complete);
            sdram_address = $urandom;
            case (n)
                1: begin
                    n_cmp++;
                    if ({avm.avm_write, avm.avm_read} !== 2'b10 ||
                        avm.avm_address !== ea || avm.avm_writedata !== d) begin
                        n_err++;
                        $display("FAIL col_write: got w,r=%b addr=%h want 10 %h",
                                 {avm.avm_write, avm.avm_read}, avm.avm_address, ea);
                    end
                end
                2: begin
                    n_cmp++;
                    if ({write_complete, read_complete, busy} !== 3'b101) begin
                        n_err++;
                        $display("FAIL col_wc: got wc,rc,busy=%b want 101",
                                 {write_complete, read_complete, busy});
                    end
                    wr_en = 0;
                end
                3: begin
                    n_cmp++;
                    if ({avm.avm_read, avm.avm_write} !== 2'b10 ||
                        avm.avm_address !== ea) begin
                        n_err++;
                        $display("FAIL col_read: got r,w=%b addr=%h want 10 %h",
                                 {avm.avm_read, avm.avm_write}, avm.avm_address, ea);
                    end
                    avm.avm_readdatavalid = 1; avm.avm_readdata = rd;
                end
                4: begin
                    avm.avm_readdatavalid = 0;
                    n_cmp++;
                    if (read_complete !== 1'b1 || read_data !== rd) begin
                        n_err++;
                        $display("FAIL col_rc: got rc=%b data=%h want 1 %h",
                                 read_complete, read_data, rd);
                    end
                    rd_en = 0;
                    model_rdata = rd;
                end
                default: ;
            endcase
        end
        n_cmp++;
        if (wc_n != 1 || rc_n != 1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL col_pulses: got wc=%0d rc=%0d busy=%b want 1 1 0",
                     wc_n, rc_n, busy);
        end
    endtask

    task automatic test_idle_valid();
        @(negedge clk);
        avm.avm_readdatavalid = 1; avm.avm_readdata = rnd128();
        @(negedge clk);
        avm.avm_readdatavalid = 0;
        n_cmp++;
        if (read_complete !== 1'b0 || read_data !== model_rdata || busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_valid: got rc=%b data=%h busy=%b want 0 %h 0",
                     read_complete, read_data, busy, model_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        @(negedge clk);
        sdram_address = $urandom; rd_en = 1; avm.avm_waitrequest = 0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({avm.avm_read, busy} !== 2'b00 || read_data !== '0) begin
            n_err++;
            $display("FAIL rst_rdwait: got r=%b busy=%b data=%h want 0 0 0",
                     avm.avm_read, busy, read_data);
        end
        model_rdata = '0;
        rd_en = 0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        avm.avm_readdatavalid = 1; avm.avm_readdata = rnd128();
        @(negedge clk);
        avm.avm_readdatavalid = 0;
        n_cmp++;
        if (read_complete !== 1'b0 || read_data !== '0) begin
            n_err++;
            $display("FAIL rst_late_valid: got rc=%b data=%h want 0 0",
                     read_complete, read_data);
        end
        @(negedge clk);
        sdram_address = $urandom; wr_en = 1; rd_en = 1;
        avm.avm_waitrequest = 1;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({avm.avm_write, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_wrreq: got w=%b busy=%b want 0 0", avm.avm_write, busy);
        end
        wr_en = 0; rd_en = 0;
        @(negedge clk); rst = 1'b1; avm.avm_waitrequest = 0;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            pulses += int'(avm.avm_read) + int'(avm.avm_write) + int'(busy) +
                      int'(write_complete) + int'(read_complete);
        end
        n_cmp++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL rst_pend_discard: got %0d active cycles want 0", pulses);
        end
    endtask

`ifdef DDR3_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        @(negedge clk);
        sdram_address = $urandom; rd_en = 1; avm.avm_waitrequest = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (read_complete !== 1'b1 && n < TMO + 20);
        rd_en = 0;
        n_cmp++;
        if (n != TMO + 1 || read_data !== '0 || error !== 1'b1) begin
            n_err++;
            $display("FAIL timeout: got cycle=%0d data=%h err=%b want %0d 0 1",
                     n, read_data, error, TMO + 1);
        end
        model_rdata = '0;
        @(negedge clk);
        avm.avm_readdatavalid = 1; avm.avm_readdata = rnd128();
        @(negedge clk);
        avm.avm_readdatavalid = 0;
        n_cmp++;
        if (read_complete !== 1'b0 || error !== 1'b1 || busy !== 1'b0 ||
            read_data !== '0) begin
            n_err++;
            $display("FAIL timeout_late: got rc=%b err=%b busy=%b want 0 1 0",
                     read_complete, error, busy);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (error !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_clear: got err=%b want 0", error);
        end
        @(negedge clk); rst = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_write(32'd5, {16{8'hA5}}, 0);
        test_write($urandom, rnd128(), 4);
        test_read(32'd1, 128'h1234, 0, 7);
        test_collision(32'd2, rnd128(), rnd128());
        test_write(32'hFFFF_FFFF, rnd128(), 1);
        test_read(32'hFFFF_FFFF, rnd128(), 2, 0);
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(1, 0) == 1)
                test_write($urandom, rnd128(), int'($urandom_range(4, 0)));
            else
                test_read($urandom, rnd128(), int'($urandom_range(4, 0)),
                          int'($urandom_range(8, 0)));
        end
        test_idle_valid();
        test_reset_mid();
`ifdef DDR3_BRIDGE_TIMEOUT_EN
        test_timeout();
`else
        n_cmp++;
        if (error !== 1'b0) begin
            n_err++;
            $display("FAIL error_tied: got %b want 0", error);
        end
`endif
        test_read($urandom, rnd128(), 1, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
